ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction fetch stage feeding the single-cycle datapath: owns the program counter, requests one 32-bit word per instruction from instruction memory over a req/ack handshake, and presents it on `inst` with a valid/ready handshake. Computes the next PC from the branch decision (`nPC_sel`) and 16-bit offset returned by the decode/control logic when the instruction is consumed.

## Interface
- `RESET_PC`, 32'h0000_0000, PC after reset; must be word aligned.
- `TIMEOUT`, 15, fetch-wait cycles before a retry (used only with `IFETCH_TIMEOUT_EN`); range 1..255.
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_req`  out  1  fetch request, held until `imem_ack`.
- `imem_addr`  out  32  word address = `pc`, bits [1:0] always 0.
- `imem_ack`  in  1  read data valid this cycle; ignored unless `imem_req`=1.
- `imem_rdata`  in  32  instruction word, sampled when `imem_req && imem_ack`.
- `inst`  out  32  registered instruction to the datapath.
- `inst_valid`  out  1  `inst` holds an unconsumed instruction.
- `inst_ready`  in  1  datapath consumes `inst` this cycle.
- `nPC_sel`  in  1  branch taken for the current `inst`; sampled on consume only.
- `br_imm16`  in  16  branch offset (instruction bits [15:0]); sampled on consume only.
- `pc`  out  32  address of the instruction in flight/held.
- `fetch_err`  out  1  one-cycle pulse on fetch timeout.

## Operation
- States: IDLE, FETCH, VALID, RETRY.
- IDLE: outputs inactive; next cycle -> FETCH.
- FETCH: `imem_req`=1, `imem_addr`=`pc` stable. On `imem_ack`: `inst`<=`imem_rdata`, -> VALID.
- VALID: `inst_valid`=1, `inst` stable. On `inst_ready`: `pc`<=next PC, -> FETCH. Without `inst_ready`: stay, nothing changes.
- Next PC: `nPC_sel`=0 -> `pc`+4; `nPC_sel`=1 -> `pc`+4+(sign_extend(`br_imm16`)<<2). 32-bit, wraps mod 2^32 (0xFFFF_FFFC+4 = 0).
- RETRY (timeout build only): `imem_req`=0 for one cycle, `pc` unchanged, -> FETCH.
- `imem_ack` in IDLE/VALID/RETRY ignored; `inst_ready` outside VALID ignored.
- `imem_req` and `inst_valid` decoded from state registers only (no combinational path from inputs).

## Timing
- Reset (async, immediate): state=IDLE, `pc`=`RESET_PC`, `inst`=0, `inst_valid`=0, `imem_req`=0, `fetch_err`=0, timeout counter=0.
- First `imem_req` in the 2nd cycle after `rst_n` rises (IDLE occupies one cycle).
- Ack in same cycle as req -> `inst_valid` next cycle. Ready in the first VALID cycle -> `imem_req` for new `pc` next cycle. Best-case throughput: one instruction per 2 cycles.
- Reset asserted mid-fetch or mid-VALID: request and held instruction abandoned; a late `imem_ack` after reset is ignored.
- Branch target available in `imem_addr` the cycle after consume.

## Configuration
- `IFETCH_TIMEOUT_EN` defined: counter counts consecutive FETCH cycles without ack; cleared on entering FETCH. When it reaches `TIMEOUT` with no ack that cycle: `fetch_err` pulses for 1 cycle, -> RETRY, re-request same `pc`. Ack on the `TIMEOUT`-th cycle wins (no error).
- Not defined: no counter, no RETRY state; FETCH waits indefinitely; `fetch_err` tied 0; `TIMEOUT` unused.

## Test plan
- Reset `RESET_PC`=0x0040_0000, memory acks same cycle, `inst_ready`=1, `nPC_sel`=0 -> `imem_addr` 0x0040_0000, 0x0040_0004, 0x0040_0008 every 2 cycles; `inst` matches memory words.
- Consume with `nPC_sel`=1, `br_imm16`=0xFFFE at `pc`=0x100 -> next `imem_addr`=0x0FC; with 0x0003 -> 0x110.
- `pc`=0xFFFF_FFFC, `nPC_sel`=0 -> next `imem_addr`=0x0000_0000.
- Ack delayed 3 cycles, then `inst_ready` held 0 for 4 cycles -> `imem_addr` stable 4 cycles, `inst`/`pc` stable while `inst_valid`=1, spurious `imem_ack` pulses in VALID ignored.
- `IFETCH_TIMEOUT_EN`, `TIMEOUT`=4, no ack -> `fetch_err` pulse after 4 FETCH cycles, `imem_req` low 1 cycle, re-request same address; ack on 4th cycle -> no `fetch_err`.
- `rst_n` low during FETCH at `pc`=0x200 -> outputs immediately at reset values, `pc`=`RESET_PC`; ack arriving during/after reset not captured.

Source files
------------

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage. Owns the PC, fetches one word per
// instruction over a req/ack handshake and hands it to the datapath over a
// valid/ready handshake. Optional fetch timeout/retry is enabled by defining
// IFETCH_TIMEOUT_EN; the default build waits indefinitely for imem_ack.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        nPC_sel,
  input  logic [15:0] br_imm16,
  output logic [31:0] pc,
  output logic        fetch_err
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2
`ifdef IFETCH_TIMEOUT_EN
    ,
    S_RETRY = 2'd3
`endif
  } state_t;

  state_t      state;
  logic [31:0] next_pc;

  // Reject a misaligned reset PC or an out-of-range timeout at elaboration.
  generate
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
      $error("ifetch_unit: RESET_PC must be word aligned");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("ifetch_unit: TIMEOUT must be in 1..255");
    end
  endgenerate

  // Sequential PC or PC-relative branch target; wraps modulo 2^32.
  assign next_pc = nPC_sel ? (pc + 32'd4 + {{14{br_imm16[15]}}, br_imm16, 2'b00})
                           : (pc + 32'd4);

  // Memory address is always the registered PC.
  assign imem_addr = pc;

`ifdef IFETCH_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt;
`else
  assign fetch_err = 1'b0;
`endif

  // Fetch FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      inst       <= 32'd0;
      inst_valid <= 1'b0;
      imem_req   <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
      fetch_err  <= 1'b0;
      wait_cnt   <= '0;
`endif
    end else begin
`ifdef IFETCH_TIMEOUT_EN
      fetch_err <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
`ifdef IFETCH_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        S_FETCH: begin
          if (imem_ack) begin
            inst       <= imem_rdata;
            inst_valid <= 1'b1;
            imem_req   <= 1'b0;
            state      <= S_VALID;
`ifdef IFETCH_TIMEOUT_EN
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            fetch_err <= 1'b1;
            imem_req  <= 1'b0;
            state     <= S_RETRY;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
`endif
          end
        end
        S_VALID: begin
          if (inst_ready) begin
            pc         <= next_pc;
            inst_valid <= 1'b0;
            imem_req   <= 1'b1;
            state      <= S_FETCH;
`ifdef IFETCH_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
          end
        end
`ifdef IFETCH_TIMEOUT_EN
        S_RETRY: begin
          imem_req <= 1'b1;
          wait_cnt <= '0;
          state    <= S_FETCH;
        end
`endif
        default: begin
          state      <= S_IDLE;
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: vector table, hand-written corner
// sequences and randomized fetch/consume traffic against a PC model.
module tb_ifetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic        nPC_sel = 1'b0;
  logic [15:0] br_imm16 = 16'd0;
  logic [31:0] pc;
  logic        fetch_err;

  int tests = 0;
  int failed = 0;
  logic [31:0] model_pc;

  ifetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .nPC_sel(nPC_sel), .br_imm16(br_imm16),
    .pc(pc), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          dly;
    int          wt;
    bit          br;
    logic [15:0] imm;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Architectural next-PC: PC + 4 + 4*signed offset, taken modulo 2^32.
  function automatic logic [31:0] model_next(input logic [31:0] p, input bit br,
                                             input logic [15:0] imm);
    longint t;
    t = longint'(p) + 64'sd4;
    if (br) t = t + 64'sd4 * longint'($signed(imm));
    return t[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One instruction: wait for req, ack after dly cycles, hold ready low wt
  // cycles (with spurious acks), then consume with the given branch inputs.
  task automatic fetch_one(input int dly, input int wt, input bit br,
                           input logic [15:0] imm, output logic [31:0] next_addr);
    int guard;
    guard = 0;
    while (imem_req !== 1'b1 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    chk("req_asserted", 32'(imem_req), 32'd1);
    chk("fetch_addr", imem_addr, model_pc);
    chk("fetch_pc", pc, model_pc);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", imem_addr, model_pc);
      chk("wait_valid", 32'(inst_valid), 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = mem_word(model_pc);
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    chk("valid_set", 32'(inst_valid), 32'd1);
    chk("inst_word", inst, mem_word(model_pc));
    chk("req_dropped", 32'(imem_req), 32'd0);
    chk("no_err", 32'(fetch_err), 32'd0);
    for (int i = 0; i < wt; i++) begin
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      @(negedge clk);
      chk("hold_valid", 32'(inst_valid), 32'd1);
      chk("hold_inst", inst, mem_word(model_pc));
      chk("hold_pc", pc, model_pc);
      chk("hold_addr", imem_addr, model_pc);
      chk("hold_req", 32'(imem_req), 32'd0);
    end
    imem_ack   = 1'b0;
    inst_ready = 1'b1;
    nPC_sel    = br;
    br_imm16   = imm;
    @(negedge clk);
    inst_ready = 1'b0;
    nPC_sel    = 1'($urandom_range(0, 1));
    br_imm16   = 16'($urandom);
    model_pc   = model_next(model_pc, br, imm);
    chk("consume_req", 32'(imem_req), 32'd1);
    chk("consume_valid", 32'(inst_valid), 32'd0);
    chk("next_addr", imem_addr, model_pc);
    next_addr = imem_addr;
  endtask

  // Walk the PC to an arbitrary target using maximal branch offsets.
  task automatic goto_pc(input logic [31:0] target);
    logic [31:0] diff;
    logic [31:0] a;
    int d;
    int off;
    for (int s = 0; s < 64 && model_pc != target; s++) begin
      diff = target - model_pc - 32'd4;
      d = int'($signed(diff));
      off = d >>> 2;
      if (off > 32767) off = 32767;
      if (off < -32768) off = -32768;
      fetch_one(0, 0, 1'b1, 16'(off), a);
    end
    chk("goto_addr", imem_addr, target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int r;

    vecs[0] = '{0, 0, 1'b0, 16'h0000, 32'h0040_0004};
    vecs[1] = '{0, 0, 1'b0, 16'h0000, 32'h0040_0008};
    vecs[2] = '{0, 0, 1'b0, 16'h0000, 32'h0040_000C};
    vecs[3] = '{3, 4, 1'b0, 16'h0000, 32'h0040_0010};
    vecs[4] = '{1, 0, 1'b1, 16'hFFFE, 32'h0040_000C};
    vecs[5] = '{0, 2, 1'b1, 16'h0003, 32'h0040_001C};
    vecs[6] = '{2, 1, 1'b1, 16'h8000, 32'h003E_0020};
    vecs[7] = '{0, 0, 1'b1, 16'h7FFF, 32'h0040_0020};

    // Reset state
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_inst", inst, 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    chk("first_req", 32'(imem_req), 32'd1);
    model_pc = RST_PC;

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      fetch_one(vecs[i].dly, vecs[i].wt, vecs[i].br, vecs[i].imm, a);
      chk($sformatf("vec%0d_next", i), a, vecs[i].exp_next);
    end

`ifdef IFETCH_TIMEOUT_EN
    // No ack: error pulse after 4 FETCH cycles, one idle cycle, re-request
    for (int i = 0; i < 3; i++) begin
      chk("to_wait_req", 32'(imem_req), 32'd1);
      chk("to_wait_err", 32'(fetch_err), 32'd0);
      @(negedge clk);
    end
    chk("to_c4_req", 32'(imem_req), 32'd1);
    @(negedge clk);
    chk("to_err_pulse", 32'(fetch_err), 32'd1);
    chk("to_req_low", 32'(imem_req), 32'd0);
    chk("to_addr_kept", imem_addr, model_pc);
    @(negedge clk);
    chk("to_err_clear", 32'(fetch_err), 32'd0);
    chk("to_rereq", 32'(imem_req), 32'd1);
    chk("to_rereq_addr", imem_addr, model_pc);
    // Ack on the 4th cycle wins
    fetch_one(3, 0, 1'b0, 16'h0000, a);
`endif

    // Randomized traffic against the PC model
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 127)) - 64;
      fetch_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 16'(r), a);
    end

    // Branch offsets at pc 0x100
    goto_pc(32'h0000_0100);
    fetch_one(0, 0, 1'b1, 16'hFFFE, a);
    chk("br_back", a, 32'h0000_00FC);
    goto_pc(32'h0000_0100);
    fetch_one(0, 0, 1'b1, 16'h0003, a);
    chk("br_fwd", a, 32'h0000_0110);

    // Wrap at top of address space
    goto_pc(32'hFFFF_FFFC);
    fetch_one(0, 0, 1'b0, 16'h0000, a);
    chk("wrap", a, 32'h0000_0000);

    // Reset asserted mid-fetch with acks around it
    goto_pc(32'h0000_0200);
    rst_n      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    #1;
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_valid", 32'(inst_valid), 32'd0);
    chk("mid_rst_pc", pc, RST_PC);
    chk("mid_rst_inst", inst, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_idle", 32'(imem_req), 32'd0);
    @(negedge clk);
    chk("post_rst_req", 32'(imem_req), 32'd1);
    chk("post_rst_valid", 32'(inst_valid), 32'd0);
    chk("post_rst_inst", inst, 32'd0);
    chk("post_rst_addr", imem_addr, RST_PC);
    imem_ack = 1'b0;
    model_pc = RST_PC;
    fetch_one(0, 0, 1'b0, 16'h0000, a);
    chk("post_rst_next", a, 32'h0040_0004);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
